tour_cmd: RTL and testbench
===========================

# tour_cmd

Replays a solved knight's tour as motion commands. It sits between the tour solver and the command processor. After the solver finishes, it steps a 5-bit move index through the 24 stored moves and reads each one-hot move back from the solver. Each move becomes two commands, a vertical leg then a horizontal leg, which are handed to the command processor with a ready/clear handshake. Outside a tour, UART commands pass straight through to the command processor.

## Interface
- No parameters.
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, synchronous, active-low; sampled on the rising edge of clk
- start_tour  in  1  one-cycle pulse from the solver's done; begins replay
- move  in  8  one-hot move read back from the solver at index mv_indx (combinational from the solver)
- mv_indx  out  5  registered index of the move being replayed
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  command valid to the command processor
- clr_cmd_rdy  in  1  command processor has consumed cmd
- send_resp  in  1  command processor has finished executing a command
- resp  out  8  response byte to the UART wrapper

## Operation
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: vertical leg 4'b0010 (move); horizontal leg 4'b0011 (move with fanfare).
  - Headings: North 8'h00, West 8'h3F, South 8'h7F, East 8'hBF.
- Move decode gives the vertical leg then the horizontal leg:
  - bit0: N2, W1
  - bit1: N2, E1
  - bit2: N1, W2
  - bit3: S1, W2
  - bit4: S2, W1
  - bit5: S2, E1
  - bit6: S1, E2
  - bit7: N1, E2
- Illegal move (not exactly one bit set): both legs are heading North with 0 squares. The sequence still advances.
- State machine: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE
    - cmd = cmd_UART; cmd_rdy = cmd_rdy_UART; resp = 8'hA5.
    - start_tour → clear mv_indx to 0, go to VERT.
  - VERT
    - cmd = vertical command; cmd_rdy = 1.
    - clr_cmd_rdy → HOLD_V.
  - HOLD_V
    - cmd holds the vertical command; cmd_rdy = 0.
    - send_resp → HORZ.
  - HORZ
    - cmd = horizontal command; cmd_rdy = 1.
    - clr_cmd_rdy → HOLD_H.
  - HOLD_H
    - cmd holds the horizontal command; cmd_rdy = 0.
    - send_resp with mv_indx==23 → IDLE, mv_indx unchanged.
    - send_resp with mv_indx<23 → mv_indx+1, go to VERT.
- resp outside IDLE:
  - 8'hA5 in HORZ/HOLD_H when mv_indx==23 (tour complete).
  - 8'h5A otherwise (intermediate move).
- During a tour, cmd_UART and cmd_rdy_UART are ignored.
- start_tour outside IDLE is ignored.

## Timing
- Reset (rst_n low at a clk edge):
  - state = IDLE, mv_indx = 0.
  - Outputs then follow IDLE rules: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 8'hA5.
- Reset mid-tour aborts at the next edge; no partial command is re-issued.
- cmd, cmd_rdy and resp are combinational from state, mv_indx and move. mv_indx and state are registered.
- Latencies:
  - start_tour to first cmd_rdy: 1 cycle.
  - clr_cmd_rdy to cmd_rdy low: 1 cycle.
  - send_resp to next cmd_rdy high: 1 cycle.
- clr_cmd_rdy is honoured only in VERT/HORZ; send_resp only in HOLD_V/HOLD_H. Either strobe seen in any other state is ignored.
- Simultaneous clr_cmd_rdy and send_resp in VERT: only clr_cmd_rdy acts. send_resp must arrive in a later cycle to leave HOLD_V.
- The move input must be stable one cycle after mv_indx changes. The solver's read port is combinational, so this holds.
- Full tour = exactly 48 cmd_rdy assertions. mv_indx never wraps past 23.

## Test plan
- Reset: hold rst_n low for 2 cycles with cmd_UART=16'h1234 and cmd_rdy_UART=1 → cmd=16'h1234, cmd_rdy=1, mv_indx=0, resp=8'hA5.
- Single move: move=8'h01, start_tour pulse →
  - cmd=16'h2002, cmd_rdy=1 the next cycle.
  - After clr_cmd_rdy then send_resp → cmd=16'h33F1.
  - After clr_cmd_rdy then send_resp → mv_indx=1, state VERT.
- Decode sweep: for each of move=8'h02…8'h80, check the vertical and horizontal commands. Example: 8'h40 → 16'h27F1 then 16'h3BF2.
- Full 24-move tour with a solver model:
  - Exactly 48 commands issued.
  - resp=8'h5A through move 22; resp=8'hA5 on move 23.
  - Returns to IDLE; cmd follows cmd_UART again.
- Handshake abuse:
  - send_resp in VERT → no state change.
  - clr_cmd_rdy in HOLD_V → no state change.
  - start_tour mid-tour → mv_indx unchanged.
  - Illegal move=8'h03 → commands 16'h2000 and 16'h3000.
- Reset mid-tour: rst_n low for 1 cycle in HOLD_H at mv_indx=7 → IDLE, mv_indx=0, UART passthrough restored.

Source files
------------

// File: rtl/tour_cmd.sv
// tour_cmd: replays a solved knight's tour as vertical/horizontal motion
// commands to the command processor; passes UART commands through when idle.
module tour_cmd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam int unsigned LAST_MOVE = 23;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] HOLD_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] HOLD_H = 3'd4;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_MOVE = 8'h5A;

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  logic [4:0]  nxt_indx;
  logic [7:0]  v_head;
  logic [3:0]  v_sq;
  logic [7:0]  h_head;
  logic [3:0]  h_sq;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        last_move;

  assign last_move = (mv_indx == 5'(LAST_MOVE));
  assign vert_cmd  = {OP_MOVE, v_head, v_sq};
  assign horz_cmd  = {OP_FANFARE, h_head, h_sq};

  // Decode the one-hot move into its two legs; anything else is a null move.
  always_comb begin
    v_head = HDG_N;
    v_sq   = 4'd0;
    h_head = HDG_N;
    h_sq   = 4'd0;
    case (move)
      8'h01: begin v_head = HDG_N; v_sq = 4'd2; h_head = HDG_W; h_sq = 4'd1; end
      8'h02: begin v_head = HDG_N; v_sq = 4'd2; h_head = HDG_E; h_sq = 4'd1; end
      8'h04: begin v_head = HDG_N; v_sq = 4'd1; h_head = HDG_W; h_sq = 4'd2; end
      8'h08: begin v_head = HDG_S; v_sq = 4'd1; h_head = HDG_W; h_sq = 4'd2; end
      8'h10: begin v_head = HDG_S; v_sq = 4'd2; h_head = HDG_W; h_sq = 4'd1; end
      8'h20: begin v_head = HDG_S; v_sq = 4'd2; h_head = HDG_E; h_sq = 4'd1; end
      8'h40: begin v_head = HDG_S; v_sq = 4'd1; h_head = HDG_E; h_sq = 4'd2; end
      8'h80: begin v_head = HDG_N; v_sq = 4'd1; h_head = HDG_E; h_sq = 4'd2; end
      default: begin end
    endcase
  end

  // State and move-index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= nxt_state;
      mv_indx <= nxt_indx;
    end
  end

  // Next state: each strobe is honoured only in the phase that expects it.
  always_comb begin
    nxt_state = state;
    nxt_indx  = mv_indx;
    case (state)
      IDLE: begin
        if (start_tour) begin
          nxt_state = VERT;
          nxt_indx  = 5'd0;
        end
      end
      VERT:   if (clr_cmd_rdy) nxt_state = HOLD_V;
      HOLD_V: if (send_resp)   nxt_state = HORZ;
      HORZ:   if (clr_cmd_rdy) nxt_state = HOLD_H;
      HOLD_H: begin
        if (send_resp) begin
          if (last_move) begin
            nxt_state = IDLE;
          end else begin
            nxt_state = VERT;
            nxt_indx  = mv_indx + 5'd1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs: UART passthrough when idle, otherwise the current leg.
  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    resp    = RESP_DONE;
    case (state)
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        resp    = RESP_MOVE;
      end
      HOLD_V: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b0;
        resp    = RESP_MOVE;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        resp    = last_move ? RESP_DONE : RESP_MOVE;
      end
      HOLD_H: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b0;
        resp    = last_move ? RESP_DONE : RESP_MOVE;
      end
      default: begin end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd: randomized bench for tour_cmd with a step-counting tour model.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  tour_mem [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a tour is 96 handshake steps; even steps await clr, odd await send.
  logic m_valid = 1'b0;
  logic m_active;
  int   m_step;
  int   m_last_idx;

  tour_cmd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp)
  );

  // Solver read port model: combinational lookup of the stored tour.
  assign move = tour_mem[mv_indx];

  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Knight displacement per move bit as (rows north, columns east).
  function automatic void knight(input logic [7:0] mv, output int dy, output int dx);
    int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx_t [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    dy = 0;
    dx = 0;
    if ($countones(mv) == 1) begin
      for (int b = 0; b < 8; b++) begin
        if (mv[b]) begin
          dy = dy_t[b];
          dx = dx_t[b];
        end
      end
    end
  endfunction

  function automatic logic [15:0] exp_vcmd(input logic [7:0] mv);
    int dy, dx;
    knight(mv, dy, dx);
    return {4'h2, (dy < 0) ? 8'h7F : 8'h00, 4'((dy < 0) ? -dy : dy)};
  endfunction

  function automatic logic [15:0] exp_hcmd(input logic [7:0] mv);
    int dy, dx;
    knight(mv, dy, dx);
    return {4'h3, (dx > 0) ? 8'hBF : ((dx < 0) ? 8'h3F : 8'h00), 4'((dx < 0) ? -dx : dx)};
  endfunction

  // Model update on each clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid    <= 1'b1;
      m_active   <= 1'b0;
      m_step     <= 0;
      m_last_idx <= 0;
    end else if (m_valid) begin
      if (!m_active) begin
        if (start_tour) begin
          m_active   <= 1'b1;
          m_step     <= 0;
          m_last_idx <= 0;
        end
      end else if ((m_step % 2 == 0) ? clr_cmd_rdy : send_resp) begin
        if (m_step == 95) begin
          m_active   <= 1'b0;
          m_last_idx <= 23;
        end else begin
          m_step <= m_step + 1;
        end
      end
    end
  end

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      int          idx;
      logic [15:0] e_cmd;
      logic        e_rdy;
      logic [7:0]  e_resp;
      if (!m_active) begin
        idx    = m_last_idx;
        e_cmd  = cmd_UART;
        e_rdy  = cmd_rdy_UART;
        e_resp = 8'hA5;
      end else begin
        idx    = m_step / 4;
        e_rdy  = (m_step % 2 == 0);
        if ((m_step % 4) >= 2) begin
          e_cmd  = exp_hcmd(tour_mem[idx]);
          e_resp = (idx == 23) ? 8'hA5 : 8'h5A;
        end else begin
          e_cmd  = exp_vcmd(tour_mem[idx]);
          e_resp = 8'h5A;
        end
      end
      check("mdl_mv_indx", 32'(mv_indx), 32'(idx));
      check("mdl_cmd", 32'(cmd), 32'(e_cmd));
      check("mdl_cmd_rdy", 32'(cmd_rdy), 32'(e_rdy));
      check("mdl_resp", 32'(resp), 32'(e_resp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  function automatic logic [7:0] rand_move();
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  // One full tour with random strobes, noise and stray start pulses.
  task automatic random_tour();
    int   rises;
    int   cycles;
    logic prev_rdy;
    logic [15:0] uart_val;
    for (int i = 0; i < 24; i++) tour_mem[i] = rand_move();
    cmd_rdy_UART = 1'b0;
    tick();
    prev_rdy   = cmd_rdy;
    rises      = 0;
    cycles     = 0;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    while (m_active && cycles < 4000) begin
      if (cmd_rdy && !prev_rdy) rises++;
      prev_rdy     = cmd_rdy;
      clr_cmd_rdy  = ($urandom_range(0, 2) == 0);
      send_resp    = ($urandom_range(0, 2) == 0);
      start_tour   = ($urandom_range(0, 15) == 0);
      cmd_UART     = 16'($urandom);
      cmd_rdy_UART = 1'($urandom);
      tick();
      cycles++;
    end
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    start_tour  = 1'b0;
    check("tour_timeout", 32'(m_active), 32'd0);
    check("tour_cmd_count", 32'(rises), 32'd48);
    check("tour_end_indx", 32'(mv_indx), 32'd23);
    uart_val     = 16'($urandom);
    cmd_UART     = uart_val;
    cmd_rdy_UART = 1'b1;
    #1;
    check("tour_end_passthru", 32'(cmd), 32'(uart_val));
    check("tour_end_resp", 32'(resp), 32'hA5);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01;
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b1;

    // Pin the model's decode against hand-computed commands.
    check("pin_v01", 32'(exp_vcmd(8'h01)), 32'h2002);
    check("pin_h01", 32'(exp_hcmd(8'h01)), 32'h33F1);
    check("pin_v40", 32'(exp_vcmd(8'h40)), 32'h27F1);
    check("pin_h40", 32'(exp_hcmd(8'h40)), 32'h3BF2);
    check("pin_v03", 32'(exp_vcmd(8'h03)), 32'h2000);
    check("pin_h03", 32'(exp_hcmd(8'h03)), 32'h3000);

    // Reset state.
    tick();
    tick();
    check("rst_cmd", 32'(cmd), 32'h1234);
    check("rst_rdy", 32'(cmd_rdy), 32'd1);
    check("rst_indx", 32'(mv_indx), 32'd0);
    check("rst_resp", 32'(resp), 32'hA5);
    rst_n        = 1'b1;
    cmd_rdy_UART = 1'b0;
    tick();

    // Single move followed by handshake abuse and an illegal move.
    tour_mem[0] = 8'h01;
    tour_mem[1] = 8'h40;
    tour_mem[2] = 8'h03;
    for (int i = 3; i < 24; i++) tour_mem[i] = rand_move();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    check("m0_vcmd", 32'(cmd), 32'h2002);
    check("m0_vrdy", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    check("m0_hold_rdy", 32'(cmd_rdy), 32'd0);
    check("m0_hold_cmd", 32'(cmd), 32'h2002);
    pulse_send();
    check("m0_hcmd", 32'(cmd), 32'h33F1);
    check("m0_hrdy", 32'(cmd_rdy), 32'd1);
    check("m0_resp", 32'(resp), 32'h5A);
    pulse_clr();
    pulse_send();
    check("m1_indx", 32'(mv_indx), 32'd1);
    check("m1_vcmd", 32'(cmd), 32'h27F1);
    check("m1_vrdy", 32'(cmd_rdy), 32'd1);
    pulse_send();
    check("abuse_send_in_vert", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    pulse_clr();
    check("abuse_clr_in_holdv", 32'(cmd_rdy), 32'd0);
    check("abuse_clr_cmd", 32'(cmd), 32'h27F1);
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    check("abuse_start_indx", 32'(mv_indx), 32'd1);
    pulse_send();
    check("m1_hcmd", 32'(cmd), 32'h3BF2);
    pulse_clr();
    pulse_send();
    check("ill_vcmd", 32'(cmd), 32'h2000);
    pulse_clr();
    pulse_send();
    check("ill_hcmd", 32'(cmd), 32'h3000);
    pulse_clr();
    for (int k = 3; k <= 7; k++) begin
      pulse_send();
      pulse_clr();
      pulse_send();
      pulse_clr();
    end
    check("mid_indx", 32'(mv_indx), 32'd7);
    check("mid_rdy", 32'(cmd_rdy), 32'd0);

    // Reset while holding the horizontal leg of move 7.
    rst_n = 1'b0;
    tick();
    rst_n        = 1'b1;
    cmd_UART     = 16'hABCD;
    cmd_rdy_UART = 1'b0;
    #1;
    check("abort_cmd", 32'(cmd), 32'hABCD);
    check("abort_rdy", 32'(cmd_rdy), 32'd0);
    check("abort_indx", 32'(mv_indx), 32'd0);
    check("abort_resp", 32'(resp), 32'hA5);
    tick();
    check("abort_idle_rdy", 32'(cmd_rdy), 32'd0);

    // Full randomized tours.
    for (int t = 0; t < 4; t++) random_tour();

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
